// File: rtl/usb_command_decoder.sv
// usb_command_decoder: decodes USB command packets into LED writes, buffer swaps and panel-select requests.
// Define CMD_ERROR_COUNT_EN to add the saturating error_count output.
module usb_command_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  data_in,
  input  logic        command_write_enable,
  input  logic        clear_psr,
  output logic        panel_select_request,
  output logic [11:0] led_addr,
  output logic [23:0] led_data,
  output logic        led_we,
  output logic        swap_buffers,
  output logic        busy
`ifdef CMD_ERROR_COUNT_EN
  ,
  output logic [7:0]  error_count
`endif
);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, RED, GREEN, BLUE} state_t;
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [23:0] tmo_q, tmo_d;
  logic [11:0] addr_buf_q, addr_buf_d;
  logic [15:0] rg_q, rg_d;
  logic [11:0] led_addr_q, led_addr_d;
  logic [23:0] led_data_q, led_data_d;
  logic psr_q, psr_d, we_q, we_d, swap_q, swap_d;
  logic stb, idle, expire;
  always_comb begin
    stb = command_write_enable;
    idle = state_q == IDLE;
    expire = !idle && !stb && tmo_q == TMO_LAST;
    state_d = state_q;
    tmo_d = (idle || stb || expire) ? 24'd0 : tmo_q + 24'd1;
    addr_buf_d = addr_buf_q;
    rg_d = rg_q;
    led_addr_d = led_addr_q;
    led_data_d = led_data_q;
    we_d = 1'b0;
    swap_d = stb && idle && data_in == 8'hC0;
    psr_d = (stb && idle && data_in == 8'hB0) ? 1'b1 : clear_psr ? 1'b0 : psr_q;
    if (expire) state_d = IDLE;
    else if (stb)
      case (state_q)
        IDLE:    state_d = data_in == 8'hA0 ? ADDR_HI : IDLE;
        ADDR_HI: begin state_d = ADDR_LO; addr_buf_d[11:8] = data_in[3:0]; end
        ADDR_LO: begin state_d = RED; addr_buf_d[7:0] = data_in; end
        RED:     begin state_d = GREEN; rg_d[15:8] = data_in; end
        GREEN:   begin state_d = BLUE; rg_d[7:0] = data_in; end
        BLUE: begin
          state_d = IDLE;
          led_addr_d = addr_buf_q;
          led_data_d = {rg_q, data_in};
          we_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_q <= '0;
      addr_buf_q <= '0;
      rg_q <= '0;
      led_addr_q <= '0;
      led_data_q <= '0;
      psr_q <= 1'b0;
      we_q <= 1'b0;
      swap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      addr_buf_q <= addr_buf_d;
      rg_q <= rg_d;
      led_addr_q <= led_addr_d;
      led_data_q <= led_data_d;
      psr_q <= psr_d;
      we_q <= we_d;
      swap_q <= swap_d;
    end
  assign panel_select_request = psr_q;
  assign led_addr = led_addr_q;
  assign led_data = led_data_q;
  assign led_we = we_q;
  assign swap_buffers = swap_q;
  assign busy = state_q != IDLE;
`ifdef CMD_ERROR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic err;
  // unknown header and timeout are mutually exclusive by state, so one increment suffices
  always_comb begin
    err = (stb && idle && data_in != 8'hA0 && data_in != 8'hB0 && data_in != 8'hC0) || expire;
    err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  assign error_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_usb_command_decoder.sv
// tb_usb_command_decoder: table-driven vectors plus hand sequences for timeout, clear_psr and reset corners.
module tb_usb_command_decoder;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [7:0] data_in = '0;
  logic command_write_enable = 1'b0, clear_psr = 1'b0;
  logic panel_select_request, led_we, swap_buffers, busy;
  logic [11:0] led_addr;
  logic [23:0] led_data;
  int errors = 0, checks = 0;
`ifdef CMD_ERROR_COUNT_EN
  logic [7:0] error_count;
`endif
  usb_command_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .command_write_enable(command_write_enable), .clear_psr(clear_psr),
    .panel_select_request(panel_select_request), .led_addr(led_addr),
    .led_data(led_data), .led_we(led_we), .swap_buffers(swap_buffers), .busy(busy)
`ifdef CMD_ERROR_COUNT_EN
    , .error_count(error_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       clr;
    logic [39:0] exp;
  } vec_t;
  function automatic logic [39:0] o(input logic p, input logic w, input logic s, input logic b,
                                    input logic [11:0] a, input logic [23:0] d);
    return {p, w, s, b, a, d};
  endfunction
  function automatic logic [39:0] outs();
    return {panel_select_request, led_we, swap_buffers, busy, led_addr, led_data};
  endfunction
  task automatic chk(input string n, input logic [39:0] a, input logic [39:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic c);
    command_write_enable = w;
    data_in = d;
    clear_psr = c;
    @(posedge clk);
    #1;
    command_write_enable = 1'b0;
    clear_psr = 1'b0;
  endtask
`ifdef CMD_ERROR_COUNT_EN
  task automatic chk_err(input string n, input logic [7:0] e);
    chk(n, {32'd0, error_count}, {32'd0, e});
  endtask
`endif
  vec_t v[24];
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0]  = '{1'b1, 8'hA0, 1'b0, o(0, 0, 0, 1, 12'h000, 24'h000000)};
    v[1]  = '{1'b1, 8'h05, 1'b0, o(0, 0, 0, 1, 12'h000, 24'h000000)};
    v[2]  = '{1'b1, 8'h3C, 1'b0, o(0, 0, 0, 1, 12'h000, 24'h000000)};
    v[3]  = '{1'b1, 8'hFF, 1'b0, o(0, 0, 0, 1, 12'h000, 24'h000000)};
    v[4]  = '{1'b1, 8'h80, 1'b0, o(0, 0, 0, 1, 12'h000, 24'h000000)};
    v[5]  = '{1'b1, 8'h01, 1'b0, o(0, 1, 0, 0, 12'h53C, 24'hFF8001)};
    v[6]  = '{1'b0, 8'hA0, 1'b0, o(0, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[7]  = '{1'b1, 8'hC0, 1'b0, o(0, 0, 1, 0, 12'h53C, 24'hFF8001)};
    v[8]  = '{1'b0, 8'h00, 1'b0, o(0, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[9]  = '{1'b1, 8'h7E, 1'b0, o(0, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[10] = '{1'b1, 8'hB0, 1'b0, o(1, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[11] = '{1'b0, 8'h00, 1'b0, o(1, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[12] = '{1'b0, 8'h00, 1'b1, o(0, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[13] = '{1'b1, 8'hB0, 1'b1, o(1, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[14] = '{1'b1, 8'hB0, 1'b0, o(1, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[15] = '{1'b0, 8'h00, 1'b1, o(0, 0, 0, 0, 12'h53C, 24'hFF8001)};
    v[16] = '{1'b1, 8'hA0, 1'b0, o(0, 0, 0, 1, 12'h53C, 24'hFF8001)};
    v[17] = '{1'b1, 8'hAF, 1'b0, o(0, 0, 0, 1, 12'h53C, 24'hFF8001)};
    v[18] = '{1'b1, 8'hFF, 1'b0, o(0, 0, 0, 1, 12'h53C, 24'hFF8001)};
    v[19] = '{1'b1, 8'hB0, 1'b0, o(0, 0, 0, 1, 12'h53C, 24'hFF8001)};
    v[20] = '{1'b1, 8'hA0, 1'b0, o(0, 0, 0, 1, 12'h53C, 24'hFF8001)};
    v[21] = '{1'b1, 8'hC0, 1'b0, o(0, 1, 0, 0, 12'hFFF, 24'hB0A0C0)};
    v[22] = '{1'b0, 8'hC0, 1'b0, o(0, 0, 0, 0, 12'hFFF, 24'hB0A0C0)};
    v[23] = '{1'b0, 8'h00, 1'b1, o(0, 0, 0, 0, 12'hFFF, 24'hB0A0C0)};
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset", outs(), '0);
`ifdef CMD_ERROR_COUNT_EN
    chk_err("reset_err", 8'd0);
`endif
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (v[i]) begin
      step(v[i].we, v[i].d, v[i].clr);
      chk($sformatf("vec%0d", i), outs(), v[i].exp);
    end
`ifdef CMD_ERROR_COUNT_EN
    chk_err("unknown_hdr_err", 8'd1);
`endif
    step(1'b1, 8'hB0, 1'b0);
    chk("psr_set", {39'd0, panel_select_request}, 40'd1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("psr_hold%0d", i), {39'd0, panel_select_request}, 40'd1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("psr_clear", {39'd0, panel_select_request}, 40'd0);
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("tmo_idle%0d", i), {38'd0, busy, led_we}, {38'd0, i < 8, 1'b0});
    end
    step(1'b0, 8'h00, 1'b0);
    chk("tmo_after", outs(), o(0, 0, 0, 0, 12'hFFF, 24'hB0A0C0));
`ifdef CMD_ERROR_COUNT_EN
    chk_err("tmo_err", 8'd2);
`endif
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h23, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("post_tmo_pkt", outs(), o(0, 1, 0, 0, 12'h123, 24'h112233));
    step(1'b1, 8'hA0, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    chk("tmo_tie_busy", {39'd0, busy}, 40'd1);
    step(1'b1, 8'h56, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b1, 8'h88, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    chk("tmo_tie_pkt", outs(), o(0, 1, 0, 0, 12'h456, 24'h778899));
`ifdef CMD_ERROR_COUNT_EN
    chk_err("tmo_tie_err", 8'd2);
`endif
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("mid_reset", outs(), '0);
    #2 reset_n = 1'b1;
    step(1'b1, 8'h05, 1'b0);
    chk("post_reset_hdr", outs(), '0);
`ifdef CMD_ERROR_COUNT_EN
    chk_err("post_reset_err", 8'd1);
`endif
    step(1'b0, 8'h00, 1'b0);
    chk("post_reset_idle", outs(), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
